regfile_mp_sb: RTL and testbench

- Parametrised multi-port integer register file for the next-generation pipelined core.
- Provides NRD combinational read ports and NWR synchronous write ports, with optional same-cycle write-to-read bypass.
- Holds a per-register busy scoreboard. Issue sets a register's busy bit; writeback clears it. The decode stage uses the busy flags for RAW-hazard stalls.
- Sits between decode/issue (read, issue) and writeback (write, clear).

---
 rtl/regfile_pkg.sv | 30 +++
 rtl/regfile_mp_sb_if.sv | 38 +++
 rtl/rf_wr_select.sv | 33 +++
 rtl/regfile_mp_sb.sv | 104 ++++++++++
 tb/tb_regfile_mp_sb.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_pkg : shared constants and helpers for the register file     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package regfile_pkg;

    localparam int RF_XLEN  = 32;
    localparam int RF_NREGS = 32;

    // Ceiling log2; returns 0 for n <= 1.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // LSB position of port k inside a packed vector of w-bit lanes.
    function automatic int port_lo(input int k, input int w);
        return k * w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_mp_sb_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_mp_sb_if : read/write/scoreboard bus of the register file    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface regfile_mp_sb_if
    import regfile_pkg::*;
#(
    parameter int XLEN  = RF_XLEN,
    parameter int NREGS = RF_NREGS,
    parameter int NRD   = 2,
    parameter int NWR   = 2
);
    localparam int AW = clog2(NREGS);

    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                issue_en;
    logic [AW-1:0]       issue_rd;
    logic                flush;
    logic                busy_any;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr, issue_en, issue_rd, flush,
        input  rd_data, rd_busy, busy_any
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr, issue_en, issue_rd, flush,
        output rd_data, rd_busy, busy_any
    );

endinterface
`default_nettype wire

// File: rtl/rf_wr_select.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rf_wr_select : which write port (highest index wins) hits an address |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rf_wr_select
    import regfile_pkg::*;
#(
    parameter int NWR = 2,
    parameter int AW  = 5,
    parameter int SW  = (NWR > 1) ? clog2(NWR) : 1
) (
    input  wire logic [NWR-1:0]    en,
    input  wire logic [NWR*AW-1:0] addr,
    input  wire logic [AW-1:0]     query,
    output logic                   hit,
    output logic [SW-1:0]          sel
);

    // Ascending scan so a later (higher) port overrides an earlier match.
    always_comb begin
        hit = 1'b0;
        sel = '0;
        for (int k = 0; k < NWR; k++) begin
            if (en[k] && (addr[port_lo(k, AW) +: AW] == query)) begin
                hit = 1'b1;
                sel = SW'(k);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_mp_sb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_mp_sb : multi-port register file with busy scoreboard        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module regfile_mp_sb
    import regfile_pkg::*;
#(
    parameter int XLEN     = RF_XLEN,
    parameter int NREGS    = RF_NREGS,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    regfile_mp_sb_if.slave  bus
);
    localparam int AW = clog2(NREGS);
    localparam int SW = (NWR > 1) ? clog2(NWR) : 1;

    logic [XLEN-1:0]  regs    [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] reg_hit;
    logic [SW-1:0]    reg_sel [NREGS];

    generate
        for (genvar r = 0; r < NREGS; r++) begin : g_reg
            rf_wr_select #(.NWR(NWR), .AW(AW), .SW(SW)) u_sel (
                .en    (bus.wr_en),
                .addr  (bus.wr_addr),
                .query (AW'(r)),
                .hit   (reg_hit[r]),
                .sel   (reg_sel[r])
            );
        end
    endgenerate

    // Issue outranks a same-cycle writeback: the new producer supersedes it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) regs[r] <= '0;
            busy <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                if (reg_hit[r] && !((ZERO_REG != 0) && (r == 0)))
                    regs[r] <= bus.wr_data[port_lo(int'(reg_sel[r]), XLEN) +: XLEN];
                if (bus.flush)
                    busy[r] <= 1'b0;
                else if (bus.issue_en && (bus.issue_rd == AW'(r)) &&
                         !((ZERO_REG != 0) && (r == 0)))
                    busy[r] <= 1'b1;
                else if (reg_hit[r])
                    busy[r] <= 1'b0;
            end
        end
    end

    generate
        for (genvar j = 0; j < NRD; j++) begin : g_rd
            logic [AW-1:0]   addr;
            logic            hit;
            logic [SW-1:0]   sel;
            logic [XLEN-1:0] data;
            logic            bsy;

            assign addr = bus.rd_addr[port_lo(j, AW) +: AW];

            if (BYPASS != 0) begin : g_byp
                rf_wr_select #(.NWR(NWR), .AW(AW), .SW(SW)) u_sel (
                    .en    (bus.wr_en),
                    .addr  (bus.wr_addr),
                    .query (addr),
                    .hit   (hit),
                    .sel   (sel)
                );
            end else begin : g_nobyp
                assign hit = 1'b0;
                assign sel = '0;
            end

            always_comb begin
                data = regs[addr];
                bsy  = busy[addr];
                if (hit) begin
                    data = bus.wr_data[port_lo(int'(sel), XLEN) +: XLEN];
                    bsy  = 1'b0;
                end
                if (((ZERO_REG != 0) && (addr == '0)) || !rst_n) begin
                    data = '0;
                    bsy  = 1'b0;
                end
            end

            assign bus.rd_data[port_lo(j, XLEN) +: XLEN] = data;
            assign bus.rd_busy[j]                        = bsy;
        end
    endgenerate

    assign bus.busy_any = rst_n & (|busy);

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp_sb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_regfile_mp_sb : directed self-checking bench (bypass and no-bypass)|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_regfile_mp_sb;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    regfile_mp_sb_if #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2)) bus ();
    regfile_mp_sb_if #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2)) nb ();

    regfile_mp_sb #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1), .ZERO_REG(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    regfile_mp_sb #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(0), .ZERO_REG(1)) dut_nb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total = total + 1;
        assert (obs === exp_v) else begin
            bad = bad + 1;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        bus.wr_en = '0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.issue_en = 1'b0; bus.issue_rd = '0; bus.flush = 1'b0;
        nb.wr_en = '0; nb.wr_addr = '0; nb.wr_data = '0;
        nb.issue_en = 1'b0; nb.issue_rd = '0; nb.flush = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        idle();
        bus.rd_addr = '0;
        nb.rd_addr  = '0;
        tick(); tick();
        rst_n = 1'b1;

        // Reset state
        bus.rd_addr = {5'd6, 5'd5}; #1;
        chk("rst_rd0", bus.rd_data[31:0], 32'h0);
        chk("rst_busy1", {31'b0, bus.rd_busy[1]}, 32'h0);
        chk("rst_busy_any", {31'b0, bus.busy_any}, 32'h0);

        // Reset mid-operation
        bus.wr_en = 2'b01; bus.wr_addr = {5'd0, 5'd5}; bus.wr_data = {32'h0, 32'hDEADBEEF};
        tick(); idle(); #1;
        chk("x5_written", bus.rd_data[31:0], 32'hDEADBEEF);
        rst_n = 1'b0;
        bus.wr_en = 2'b01; bus.wr_addr = {5'd0, 5'd6}; bus.wr_data = {32'h0, 32'h1};
        bus.issue_en = 1'b1; bus.issue_rd = 5'd7;
        bus.rd_addr = {5'd5, 5'd6}; #1;
        chk("in_rst_rd_x6", bus.rd_data[31:0], 32'h0);
        chk("in_rst_rd_x5", bus.rd_data[63:32], 32'h0);
        tick(); rst_n = 1'b1; idle();
        bus.rd_addr = {5'd6, 5'd5}; #1;
        chk("post_rst_x5", bus.rd_data[31:0], 32'h0);
        chk("post_rst_x6", bus.rd_data[63:32], 32'h0);
        bus.rd_addr = {5'd7, 5'd0}; #1;
        chk("post_rst_busy7", {31'b0, bus.rd_busy[1]}, 32'h0);
        chk("post_rst_busy_any", {31'b0, bus.busy_any}, 32'h0);

        // Two ports, distinct addresses
        bus.wr_en = 2'b11; bus.wr_addr = {5'd2, 5'd1}; bus.wr_data = {32'h0000000B, 32'h0000000A};
        tick(); idle();
        bus.rd_addr = {5'd2, 5'd1}; #1;
        chk("dual_x1", bus.rd_data[31:0], 32'h0000000A);
        chk("dual_x2", bus.rd_data[63:32], 32'h0000000B);

        // Write-port conflict: highest port wins
        bus.wr_en = 2'b11; bus.wr_addr = {5'd3, 5'd3}; bus.wr_data = {32'h22, 32'h11};
        bus.rd_addr = {5'd1, 5'd3}; #1;
        chk("conflict_bypass", bus.rd_data[31:0], 32'h22);
        tick(); idle(); #1;
        chk("conflict_stored", bus.rd_data[31:0], 32'h22);

        // Zero register
        bus.wr_en = 2'b01; bus.wr_addr = {5'd0, 5'd0}; bus.wr_data = {32'h0, 32'hFFFFFFFF};
        bus.issue_en = 1'b1; bus.issue_rd = 5'd0;
        bus.rd_addr = {5'd0, 5'd0}; #1;
        chk("x0_same_cycle", bus.rd_data[31:0], 32'h0);
        tick(); idle(); #1;
        chk("x0_data", bus.rd_data[31:0], 32'h0);
        chk("x0_busy", {31'b0, bus.rd_busy[0]}, 32'h0);
        chk("x0_busy_any", {31'b0, bus.busy_any}, 32'h0);

        // Scoreboard round trip on x10
        bus.issue_en = 1'b1; bus.issue_rd = 5'd10;
        bus.rd_addr = {5'd0, 5'd10}; #1;
        chk("x10_issue_same_cycle", {31'b0, bus.rd_busy[0]}, 32'h0);
        tick(); idle(); #1;
        chk("x10_busy", {31'b0, bus.rd_busy[0]}, 32'h1);
        chk("x10_busy_any", {31'b0, bus.busy_any}, 32'h1);
        bus.wr_en = 2'b10; bus.wr_addr = {5'd10, 5'd0}; bus.wr_data = {32'h1234, 32'h0}; #1;
        chk("x10_wb_busy", {31'b0, bus.rd_busy[0]}, 32'h0);
        chk("x10_wb_data", bus.rd_data[31:0], 32'h1234);
        chk("x10_wb_busy_any_reg", {31'b0, bus.busy_any}, 32'h1);
        tick(); idle(); #1;
        chk("x10_after_busy_any", {31'b0, bus.busy_any}, 32'h0);
        chk("x10_after_data", bus.rd_data[31:0], 32'h1234);

        // Simultaneous issue and writeback of x12
        bus.wr_en = 2'b01; bus.wr_addr = {5'd0, 5'd12}; bus.wr_data = {32'h0, 32'hABCD};
        bus.issue_en = 1'b1; bus.issue_rd = 5'd12;
        tick(); idle();
        bus.rd_addr = {5'd13, 5'd12}; #1;
        chk("x12_busy", {31'b0, bus.rd_busy[0]}, 32'h1);
        chk("x12_data", bus.rd_data[31:0], 32'hABCD);
        chk("x12_busy_any", {31'b0, bus.busy_any}, 32'h1);

        // Flush beats a same-cycle issue
        bus.flush = 1'b1; bus.issue_en = 1'b1; bus.issue_rd = 5'd13;
        tick(); idle(); #1;
        chk("flush_x12", {31'b0, bus.rd_busy[0]}, 32'h0);
        chk("flush_x13", {31'b0, bus.rd_busy[1]}, 32'h0);
        chk("flush_busy_any", {31'b0, bus.busy_any}, 32'h0);
        chk("flush_keeps_data", bus.rd_data[31:0], 32'hABCD);

        // No-bypass build
        nb.wr_en = 2'b01; nb.wr_addr = {5'd0, 5'd4}; nb.wr_data = {32'h0, 32'h55};
        nb.issue_en = 1'b1; nb.issue_rd = 5'd9;
        nb.rd_addr = {5'd0, 5'd4}; #1;
        chk("nb_x4_old", nb.rd_data[31:0], 32'h0);
        tick(); idle(); #1;
        chk("nb_x4_new", nb.rd_data[31:0], 32'h55);
        nb.wr_en = 2'b10; nb.wr_addr = {5'd9, 5'd0}; nb.wr_data = {32'h77, 32'h0};
        nb.rd_addr = {5'd0, 5'd9}; #1;
        chk("nb_x9_busy_during_wb", {31'b0, nb.rd_busy[0]}, 32'h1);
        chk("nb_x9_old_data", nb.rd_data[31:0], 32'h0);
        tick(); idle(); #1;
        chk("nb_x9_released", {31'b0, nb.rd_busy[0]}, 32'h0);
        chk("nb_x9_data", nb.rd_data[31:0], 32'h77);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
